// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the MEM stage bus controller: FSM states, op codes,
// byte-lane constants and the store-side lane/replication helpers.
package mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    MemIdle = 2'd0,
    MemBusy = 2'd1,
    MemDone = 2'd2
  } mem_state_e;

  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [3:0] SEL_NONE    = 4'b0000;
  localparam logic [3:0] SEL_BYTE0   = 4'b1000;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_WORD    = 4'b1111;

  function automatic logic is_load(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if ((op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP))
      bad = addr_lo[0];
    else if ((op == EXE_LW_OP) || (op == EXE_SW_OP))
      bad = |addr_lo;
    return bad;
  endfunction

  // Big-endian lanes: byte address 0 lives in bits [31:24].
  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] addr_lo);
    logic [3:0] sel;
    sel = SEL_NONE;
    if ((op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_SB_OP))
      sel = SEL_BYTE0 >> addr_lo;
    else if ((op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP))
      sel = addr_lo[1] ? SEL_HALF_LO : SEL_HALF_HI;
    else if ((op == EXE_LW_OP) || (op == EXE_SW_OP))
      sel = SEL_WORD;
    return sel;
  endfunction

  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] sdata);
    logic [31:0] data;
    data = 32'h0;
    if (op == EXE_SB_OP)
      data = {4{sdata[7:0]}};
    else if (op == EXE_SH_OP)
      data = {2{sdata[15:0]}};
    else if (op == EXE_SW_OP)
      data = sdata;
    return data;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_load_align.sv
// Selects the addressed byte/half of a big-endian read word and extends it
// according to the load op.
module mem_load_align
  import mem_bus_ctrl_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[31:24];
    case (addr_lo)
      2'd0: byte_val = rdata[31:24];
      2'd1: byte_val = rdata[23:16];
      2'd2: byte_val = rdata[15:8];
      2'd3: byte_val = rdata[7:0];
      default: byte_val = rdata[31:24];
    endcase
    half_val = addr_lo[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    load_data = rdata;
    case (aluop)
      EXE_LB_OP:  load_data = {{24{byte_val[7]}}, byte_val};
      EXE_LBU_OP: load_data = {24'h0, byte_val};
      EXE_LH_OP:  load_data = {{16{half_val[15]}}, half_val};
      EXE_LHU_OP: load_data = {16'h0, half_val};
      default:    load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM pipeline stage: runs loads/stores over a req/ack bus with a stalling
// IDLE/BUSY/DONE FSM and passes non-memory ops straight to mem_wb.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_maddr,
  input  logic [31:0] mem_sdata,
  input  logic [4:0]  mem_waddr_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        mem_whilo_i,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  output logic [4:0]  mem_waddr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        stallreq_mem,
  output logic        mem_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(BUS_TIMEOUT - 1);

  mem_state_e  state, state_next;
  logic [7:0]  busy_cnt;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] load_data;
  logic        mem_access;
  logic        misaligned;
  logic        timeout;

  assign mem_access = is_mem_op(mem_aluop);
  assign misaligned = is_misaligned(mem_aluop, mem_maddr[1:0]);
  assign timeout    = (busy_cnt == TIMEOUT_LAST);

  mem_load_align u_load_align (
    .aluop     (mem_aluop),
    .addr_lo   (mem_maddr[1:0]),
    .rdata     (rdata_q),
    .load_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      state <= MemIdle;
    else
      state <= state_next;
  end

  // Bus outputs are loaded on the IDLE->BUSY edge and held until ack or abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_cnt  <= 8'd0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_sel   <= 4'h0;
      bus_wdata <= 32'h0;
    end else begin
      case (state)
        MemIdle: begin
          busy_cnt <= 8'd0;
          err_q    <= mem_access && misaligned;
          if (mem_access && !misaligned) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store(mem_aluop);
            bus_addr  <= {mem_maddr[31:2], 2'b00};
            bus_sel   <= lane_sel(mem_aluop, mem_maddr[1:0]);
            bus_wdata <= store_data(mem_aluop, mem_sdata);
          end
        end
        MemBusy: begin
          busy_cnt <= busy_cnt + 8'd1;
          if (bus_ack) begin
            rdata_q <= bus_rdata;
            bus_req <= 1'b0;
          end else if (timeout) begin
            err_q   <= 1'b1;
            bus_req <= 1'b0;
          end
        end
        MemDone: begin
          busy_cnt <= 8'd0;
          err_q    <= 1'b0;
        end
        default: begin
          busy_cnt <= 8'd0;
          err_q    <= 1'b0;
          bus_req  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    stallreq_mem = 1'b0;
    mem_err      = 1'b0;
    mem_waddr    = mem_waddr_i;
    mem_we       = mem_we_i;
    mem_wdata    = mem_wdata_i;
    mem_whilo    = mem_whilo_i;
    mem_hi       = mem_hi_i;
    mem_lo       = mem_lo_i;
    case (state)
      MemIdle: begin
        if (mem_access) begin
          stallreq_mem = 1'b1;
          state_next   = misaligned ? MemDone : MemBusy;
        end
      end
      MemBusy: begin
        stallreq_mem = 1'b1;
        if (bus_ack || timeout)
          state_next = MemDone;
      end
      MemDone: begin
        state_next = MemIdle;
        if (err_q) begin
          mem_we    = 1'b0;
          mem_whilo = 1'b0;
          mem_err   = 1'b1;
        end else if (is_load(mem_aluop)) begin
          mem_wdata = load_data;
        end
      end
      default: state_next = MemIdle;
    endcase
  end

endmodule
